piso_tx_arbiter: RTL and testbench
==================================

PISO_TX_ARBITER -- requirements
Module: piso_tx_arbiter

Interface
REQ-001 Parameter GAP_CYCLES, default 1, sets the number of idle cycles inserted between consecutive frames (legal range 0..7).
REQ-002 clk  input  1  clock; all logic SHALL be rising-edge triggered.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 req  input  4  per-requester level request; bit i = requester i.
REQ-005 wdata  input  16  requester words; requester i owns bits [4i+3:4i].
REQ-006 ack  output  4  one-hot, one-cycle pulse; the requester's word is taken this cycle.
REQ-007 sdout  output  1  serial data, MSB first.
REQ-008 sout_valid  output  1  high while sdout carries a frame bit.
REQ-009 sout_id  output  2  index of the requester owning the current frame; valid when sout_valid=1.
REQ-010 busy  output  1  high whenever state is not IDLE.

Function
REQ-011 The FSM SHALL have states IDLE, SHIFT and GAP.
REQ-012 IDLE with req==0: the FSM SHALL stay in IDLE with ack=0.
REQ-013 IDLE with req!=0: the block SHALL select one requester by round-robin, starting at last_grant+1 and wrapping modulo 4.
REQ-014 In that same IDLE cycle the block SHALL assert ack[sel]=1, load wdata[sel] into the shifter, register sel into sout_id and last_grant, and move to SHIFT.
REQ-015 SHIFT SHALL last exactly 4 cycles, with sout_valid=1 and sdout equal to word bits 3,2,1,0 in that order; a 2-bit counter tracks bit position.
REQ-016 Latency SHALL be fixed: the MSB appears on sdout in the first cycle after ack.
REQ-017 After the 4th SHIFT cycle the FSM SHALL go to GAP for GAP_CYCLES cycles, then to IDLE.
REQ-018 If GAP_CYCLES=0, the FSM SHALL go directly from SHIFT to IDLE.
REQ-019 Back-to-back frame period SHALL be 5+GAP_CYCLES cycles (ack to ack).
REQ-020 Outside SHIFT: sout_valid=0 and sdout=0, because the shifter fills with zeros.
REQ-021 At most one ack bit SHALL be high in any cycle, and ack SHALL be 0 outside IDLE.
REQ-022 A requester that is not granted SHALL keep req and its word stable until it sees ack; a deasserted req is simply not considered.
REQ-023 After ack, the requester SHALL drop req or present its next word in the following cycle.
REQ-024 Requests arriving in SHIFT or GAP SHALL be held pending and arbitrated at the next IDLE cycle; no request is lost.
REQ-025 A single persistent requester with all others idle SHALL be granted every frame.
REQ-026 Fairness: with all 4 requesters asserted continuously, grant order SHALL be 0,1,2,3,0,...

Reset
REQ-027 rst SHALL take priority over all other inputs, in any state.
REQ-028 On rst the block SHALL force: state=IDLE, counters=0, shifter=0, ack=0, sdout=0, sout_valid=0, sout_id=0, busy=0.
REQ-029 On rst, last_grant SHALL be set to 3 so that requester 0 has first priority after reset.
REQ-030 Reset during SHIFT SHALL abort the frame; sout_valid SHALL be 0 from the cycle after the reset edge. A partial frame is not resumed.

Structure
REQ-031 Package piso_arb_pkg SHALL hold NUM_REQ=4, WORD_W=4, the FSM state encoding and the GAP_CYCLES default.
REQ-032 The block SHALL instantiate one sub-module, piso_shift_register_4bit (load/shift-left, serial out from bit 3), as the datapath.
REQ-033 The arbiter and FSM SHALL live in piso_tx_arbiter; the round-robin select is combinational from req and last_grant.

Verification
REQ-034 Reset then req=0001, wdata[3:0]=1101 -> ack=0001 for 1 cycle; next 4 cycles sdout=1,1,0,1 with sout_valid=1 and sout_id=0; then busy=0 after 1 GAP cycle.
REQ-035 req=1111 held, words 1000/0100/0010/0001 for requesters 0..3 -> acks 0,1,2,3,0 spaced 6 cycles apart; each frame is its own word MSB first.
REQ-036 req[2] raised in the 2nd SHIFT cycle of a requester-0 frame -> ack[2] in the first IDLE cycle after GAP; no ack during SHIFT or GAP.
REQ-037 rst pulsed in the 3rd SHIFT cycle of word 1010 -> sout_valid=0 and sdout=0 the next cycle; with req=0001 still high, a fresh ack[0] occurs the cycle after rst drops.
REQ-038 GAP_CYCLES=0 with req=0010 held, word 0110 -> frames back to back, ack every 5 cycles, sdout stream 0110 0110.
REQ-039 Every scenario SHALL run a continuous check that ack is one-hot or zero and that sout_valid is never high outside the 4 cycles following an ack.

Source files
------------

// File: rtl/piso_arb_pkg.sv
// rtl/piso_arb_pkg.sv - shared constants, FSM encoding and round-robin helper for the PISO transmit arbiter
package piso_arb_pkg;

    localparam int NUM_REQ        = 4;
    localparam int WORD_W         = 4;
    localparam int GAP_CYCLES_DEF = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    // First asserted requester searching upward from last+1, wrapping modulo NUM_REQ.
    function automatic logic [1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                           input logic [1:0]         last);
        logic [1:0] idx;
        logic       found;
        logic [1:0] pick;
        found = 1'b0;
        pick  = 2'd0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = last + 2'(k);
            if (!found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/piso_shift_register_4bit.sv
// rtl/piso_shift_register_4bit.sv - 4-bit parallel-load, shift-left register with serial output from bit 3
module piso_shift_register_4bit
    import piso_arb_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              shift,
    input  logic [WORD_W-1:0] din,
    output logic              sdout
);

    logic [WORD_W-1:0] q;

    // Zero fill means the register is empty after a full frame, so sdout idles low.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= din;
        end else if (shift) begin
            q <= {q[WORD_W-2:0], 1'b0};
        end
    end

    assign sdout = q[WORD_W-1];

endmodule

// File: rtl/piso_tx_arbiter.sv
// rtl/piso_tx_arbiter.sv - round-robin arbiter serialising 4-bit words from four requesters, MSB first
module piso_tx_arbiter
    import piso_arb_pkg::*;
#(
    parameter int GAP_CYCLES = GAP_CYCLES_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*WORD_W-1:0] wdata,
    output logic [NUM_REQ-1:0]        ack,
    output logic                      sdout,
    output logic                      sout_valid,
    output logic [1:0]                sout_id,
    output logic                      busy
);

    localparam logic [2:0] GAP_LAST = 3'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

    state_t            state, state_nxt;
    logic [1:0]        bit_cnt, bit_cnt_nxt;
    logic [2:0]        gap_cnt, gap_cnt_nxt;
    logic [1:0]        last_grant, last_grant_nxt;
    logic [1:0]        id_nxt;
    logic [1:0]        sel;
    logic [WORD_W-1:0] word_sel;
    logic              load;
    logic              shift;

    assign sel      = rr_pick(req, last_grant);
    assign word_sel = wdata[{sel, 2'b00} +: WORD_W];

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            bit_cnt    <= '0;
            gap_cnt    <= '0;
            last_grant <= 2'(NUM_REQ - 1);
            sout_id    <= '0;
        end else begin
            state      <= state_nxt;
            bit_cnt    <= bit_cnt_nxt;
            gap_cnt    <= gap_cnt_nxt;
            last_grant <= last_grant_nxt;
            sout_id    <= id_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        bit_cnt_nxt    = bit_cnt;
        gap_cnt_nxt    = gap_cnt;
        last_grant_nxt = last_grant;
        id_nxt         = sout_id;
        ack            = '0;
        load           = 1'b0;
        shift          = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req != '0) begin
                    ack[sel]       = 1'b1;
                    load           = 1'b1;
                    id_nxt         = sel;
                    last_grant_nxt = sel;
                    bit_cnt_nxt    = '0;
                    state_nxt      = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                shift       = 1'b1;
                bit_cnt_nxt = bit_cnt + 2'd1;
                if (bit_cnt == 2'd3) begin
                    gap_cnt_nxt = '0;
                    state_nxt   = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
                end
            end
            ST_GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    gap_cnt_nxt = '0;
                    state_nxt   = ST_IDLE;
                end else begin
                    gap_cnt_nxt = gap_cnt + 3'd1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        // Reset wins even over the combinational grant in IDLE.
        if (rst) begin
            ack   = '0;
            load  = 1'b0;
            shift = 1'b0;
        end
    end

    piso_shift_register_4bit u_shift (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .shift (shift),
        .din   (word_sel),
        .sdout (sdout)
    );

    assign sout_valid = (state == ST_SHIFT);
    assign busy       = (state != ST_IDLE);

endmodule

// File: tb/tb_piso_tx_arbiter.sv
// tb/tb_piso_tx_arbiter.sv - directed self-checking bench for piso_tx_arbiter (GAP_CYCLES=1 and 0)
module tb_piso_tx_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req, req0;
    logic [15:0] wdata, wdata0;
    logic [3:0]  ack, ack0;
    logic        sdout, sdout0;
    logic        sout_valid, sout_valid0;
    logic [1:0]  sout_id, sout_id0;
    logic        busy, busy0;

    int checks;
    int failures;
    int since1;
    int since0;

    piso_tx_arbiter #(.GAP_CYCLES(1)) dut (
        .clk(clk), .rst(rst), .req(req), .wdata(wdata), .ack(ack),
        .sdout(sdout), .sout_valid(sout_valid), .sout_id(sout_id), .busy(busy)
    );

    piso_tx_arbiter #(.GAP_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .req(req0), .wdata(wdata0), .ack(ack0),
        .sdout(sdout0), .sout_valid(sout_valid0), .sout_id(sout_id0), .busy(busy0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Continuous: ack one-hot or zero, sout_valid only in the 4 cycles after an ack.
    initial begin
        since1 = 100;
        since0 = 100;
        forever begin
            @(negedge clk);
            since1++;
            since0++;
            checks++;
            if ((ack & (ack - 4'd1)) !== 4'd0) begin
                failures++;
                $display("FAIL mon_onehot got=%b", ack);
            end
            checks++;
            if (sout_valid === 1'b1 && (since1 < 1 || since1 > 4)) begin
                failures++;
                $display("FAIL mon_valid_window got=1 since_ack=%0d required=1..4", since1);
            end
            checks++;
            if ((ack0 & (ack0 - 4'd1)) !== 4'd0) begin
                failures++;
                $display("FAIL mon_onehot_g0 got=%b", ack0);
            end
            checks++;
            if (sout_valid0 === 1'b1 && (since0 < 1 || since0 > 4)) begin
                failures++;
                $display("FAIL mon_valid_window_g0 got=1 since_ack=%0d required=1..4", since0);
            end
            if (ack != 4'd0) since1 = 0;
            if (ack0 != 4'd0) since0 = 0;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst   = 1'b1;
        req   = 4'b1111;
        wdata = 16'hA5C3;
        tick;
        tick;
        @(negedge clk);
        checks++;
        if (ack !== 4'd0 || ack0 !== 4'd0) begin
            failures++;
            $display("FAIL reset_ack got=%b/%b required=0000", ack, ack0);
        end
        checks++;
        if ({sout_valid, sdout, sout_id, busy} !== 5'b0) begin
            failures++;
            $display("FAIL reset_outputs got=%b required=00000", {sout_valid, sdout, sout_id, busy});
        end
        checks++;
        if ({sout_valid0, sdout0, sout_id0, busy0} !== 5'b0) begin
            failures++;
            $display("FAIL reset_outputs_g0 got=%b required=00000", {sout_valid0, sdout0, sout_id0, busy0});
        end
        tick;
        rst = 1'b0;
        req = 4'b0000;
        @(negedge clk);
        checks++;
        if (ack !== 4'd0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL idle_no_req got ack=%b busy=%b required 0000/0", ack, busy);
        end
        tick;
    endtask

    task automatic test_single;
        logic [3:0] w;
        w     = 4'b1101;
        req   = 4'b0001;
        wdata = {12'h000, w};
        @(negedge clk);
        checks++;
        if (ack !== 4'b0001 || busy !== 1'b0) begin
            failures++;
            $display("FAIL single_ack got ack=%b busy=%b required 0001/0", ack, busy);
        end
        tick;
        req = 4'b0000;
        for (int b = 3; b >= 0; b--) begin
            @(negedge clk);
            checks++;
            if ({sout_valid, sout_id, sdout, busy, ack} !== {1'b1, 2'd0, w[b], 1'b1, 4'd0}) begin
                failures++;
                $display("FAIL single_bit%0d got=%b required=%b", b,
                         {sout_valid, sout_id, sdout, busy, ack}, {1'b1, 2'd0, w[b], 1'b1, 4'd0});
            end
            tick;
        end
        @(negedge clk);
        checks++;
        if ({sout_valid, sdout, busy} !== 3'b001) begin
            failures++;
            $display("FAIL single_gap got=%b required=001", {sout_valid, sdout, busy});
        end
        tick;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || ack !== 4'd0) begin
            failures++;
            $display("FAIL single_done got busy=%b ack=%b required 0/0000", busy, ack);
        end
        tick;
    endtask

    task automatic test_fairness;
        logic [3:0] words [4];
        logic [3:0] w;
        int         g;
        words[0] = 4'b1000;
        words[1] = 4'b0100;
        words[2] = 4'b0010;
        words[3] = 4'b0001;
        rst = 1'b1;
        tick;
        rst   = 1'b0;
        req   = 4'b1111;
        wdata = {words[3], words[2], words[1], words[0]};
        for (int f = 0; f < 5; f++) begin
            g = f % 4;
            w = words[g];
            @(negedge clk);
            checks++;
            if (ack !== (4'b0001 << g)) begin
                failures++;
                $display("FAIL fair_ack%0d got=%b required=%b", f, ack, 4'b0001 << g);
            end
            tick;
            for (int b = 3; b >= 0; b--) begin
                @(negedge clk);
                checks++;
                if ({sout_valid, sout_id, sdout, ack} !== {1'b1, 2'(g), w[b], 4'd0}) begin
                    failures++;
                    $display("FAIL fair_f%0d_bit%0d got=%b required=%b", f, b,
                             {sout_valid, sout_id, sdout, ack}, {1'b1, 2'(g), w[b], 4'd0});
                end
                tick;
            end
            @(negedge clk);
            checks++;
            if ({ack, sout_valid, busy} !== 6'b000001) begin
                failures++;
                $display("FAIL fair_gap%0d got=%b required=000001", f, {ack, sout_valid, busy});
            end
            tick;
        end
        req = 4'b0000;
        @(negedge clk);
        checks++;
        if (ack !== 4'd0) begin
            failures++;
            $display("FAIL fair_release got=%b required=0000", ack);
        end
        tick;
    endtask

    task automatic test_pending;
        logic [3:0] w;
        w     = 4'b1011;
        req   = 4'b0001;
        wdata = 16'h0009;
        @(negedge clk);
        checks++;
        if (ack !== 4'b0001) begin
            failures++;
            $display("FAIL pend_first_ack got=%b required=0001", ack);
        end
        tick;
        req = 4'b0000;
        @(negedge clk);
        tick;
        req   = 4'b0100;
        wdata = {4'h0, w, 8'h09};
        for (int c = 2; c <= 5; c++) begin
            @(negedge clk);
            checks++;
            if (ack !== 4'd0 || busy !== 1'b1) begin
                failures++;
                $display("FAIL pend_hold_c%0d got ack=%b busy=%b required 0000/1", c, ack, busy);
            end
            tick;
        end
        @(negedge clk);
        checks++;
        if (ack !== 4'b0100 || busy !== 1'b0) begin
            failures++;
            $display("FAIL pend_grant got ack=%b busy=%b required 0100/0", ack, busy);
        end
        tick;
        req = 4'b0000;
        for (int b = 3; b >= 0; b--) begin
            @(negedge clk);
            checks++;
            if ({sout_valid, sout_id, sdout} !== {1'b1, 2'd2, w[b]}) begin
                failures++;
                $display("FAIL pend_bit%0d got=%b required=%b", b,
                         {sout_valid, sout_id, sdout}, {1'b1, 2'd2, w[b]});
            end
            tick;
        end
        tick;
    endtask

    task automatic test_reset_abort;
        logic [3:0] w;
        w     = 4'b1010;
        req   = 4'b0001;
        wdata = {12'h000, w};
        @(negedge clk);
        checks++;
        if (ack !== 4'b0001) begin
            failures++;
            $display("FAIL abort_ack got=%b required=0001", ack);
        end
        tick;
        tick;
        tick;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({sout_valid, sdout, ack} !== {1'b1, w[1], 4'd0}) begin
            failures++;
            $display("FAIL abort_third_bit got=%b required=%b", {sout_valid, sdout, ack}, {1'b1, w[1], 4'd0});
        end
        tick;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({sout_valid, sdout, busy} !== 3'b000) begin
            failures++;
            $display("FAIL abort_cleared got=%b required=000", {sout_valid, sdout, busy});
        end
        checks++;
        if (ack !== 4'b0001) begin
            failures++;
            $display("FAIL abort_regrant got=%b required=0001", ack);
        end
        tick;
        req = 4'b0000;
        for (int b = 3; b >= 0; b--) begin
            @(negedge clk);
            checks++;
            if ({sout_valid, sdout} !== {1'b1, w[b]}) begin
                failures++;
                $display("FAIL abort_refresh_bit%0d got=%b required=%b", b, {sout_valid, sdout}, {1'b1, w[b]});
            end
            tick;
        end
        tick;
    endtask

    task automatic test_gap0;
        logic [3:0] w;
        w      = 4'b0110;
        req0   = 4'b0010;
        wdata0 = {8'h00, w, 4'h0};
        for (int f = 0; f < 2; f++) begin
            @(negedge clk);
            checks++;
            if (ack0 !== 4'b0010 || busy0 !== 1'b0) begin
                failures++;
                $display("FAIL gap0_ack%0d got ack=%b busy=%b required 0010/0", f, ack0, busy0);
            end
            tick;
            for (int b = 3; b >= 0; b--) begin
                @(negedge clk);
                checks++;
                if ({sout_valid0, sout_id0, sdout0, ack0} !== {1'b1, 2'd1, w[b], 4'd0}) begin
                    failures++;
                    $display("FAIL gap0_f%0d_bit%0d got=%b required=%b", f, b,
                             {sout_valid0, sout_id0, sdout0, ack0}, {1'b1, 2'd1, w[b], 4'd0});
                end
                tick;
            end
        end
        req0 = 4'b0000;
        @(negedge clk);
        checks++;
        if (ack0 !== 4'd0 || busy0 !== 1'b0 || sout_valid0 !== 1'b0) begin
            failures++;
            $display("FAIL gap0_end got ack=%b busy=%b valid=%b required 0000/0/0", ack0, busy0, sout_valid0);
        end
        tick;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        req      = 4'b0000;
        wdata    = 16'h0000;
        req0     = 4'b0000;
        wdata0   = 16'h0000;
        test_reset;
        test_single;
        test_fairness;
        test_pending;
        test_reset_abort;
        test_gap0;
        tick;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
